// File: rtl/pc_unit.sv
// Registered program counter for the RV32 fetch stage: reset vector, stall,
// redirect, trap entry, halt/resume, optional flush bubble and misaligned-target capture.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4,
  parameter bit              FLUSH_BUBBLE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            halt_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            pc_valid_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  // Compressed builds only require halfword alignment.
  localparam logic [XLEN-1:0] ALIGN_MASK = (INC == 2) ? XLEN'(1) : XLEN'(3);

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr & ALIGN_MASK) == '0;
  endfunction

  function automatic logic [XLEN-1:0] force_align(input logic [XLEN-1:0] addr);
    return addr & ~ALIGN_MASK;
  endfunction

  state_t          state_p0, state_nxt;
  logic [XLEN-1:0] pc_p0, pc_nxt;
  logic            bubble_p0, bubble_nxt;
  logic            misalign_p0, misalign_nxt;
  logic [XLEN-1:0] misalign_addr_p0, misalign_addr_nxt;
  logic            vld_p0;
  logic [XLEN-1:0] pc_plus;

  assign pc_plus = pc_p0 + XLEN'(INC);
  assign vld_p0  = (state_p0 == RUN) && !bubble_p0;

  always_comb begin
    state_nxt         = state_p0;
    pc_nxt            = pc_p0;
    bubble_nxt        = 1'b0;
    misalign_nxt      = 1'b0;
    misalign_addr_nxt = misalign_addr_p0;
    case (state_p0)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (trap_i) begin
          pc_nxt     = force_align(trap_vec_i);
          bubble_nxt = FLUSH_BUBBLE;
        end else if (redirect_i) begin
          if (is_aligned(redirect_target_i)) begin
            pc_nxt     = redirect_target_i;
            bubble_nxt = FLUSH_BUBBLE;
          end else begin
            misalign_nxt      = 1'b1;
            misalign_addr_nxt = redirect_target_i;
          end
        end else if (halt_i) begin
          state_nxt = HALT;
        end else if (!stall_i && !bubble_p0) begin
          // The bubble cycle re-presents the target rather than advancing past it.
          pc_nxt = pc_plus;
        end
      end
      HALT: begin
        if (trap_i) begin
          state_nxt  = RUN;
          pc_nxt     = force_align(trap_vec_i);
          bubble_nxt = FLUSH_BUBBLE;
        end else if (resume_i) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Stage 0: fetch PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0         <= BOOT;
      pc_p0            <= RESET_VECTOR;
      bubble_p0        <= 1'b0;
      misalign_p0      <= 1'b0;
      misalign_addr_p0 <= '0;
    end else begin
      state_p0         <= state_nxt;
      pc_p0            <= pc_nxt;
      bubble_p0        <= bubble_nxt;
      misalign_p0      <= misalign_nxt;
      misalign_addr_p0 <= misalign_addr_nxt;
    end
  end

  assign pc_o            = pc_p0;
  assign pc_plus_o       = pc_plus;
  assign pc_valid_o      = vld_p0;
  assign misalign_o      = misalign_p0;
  assign misalign_addr_o = misalign_addr_p0;
  assign state_o         = state_p0;

endmodule
